vec_norm: RTL and testbench
===========================

Name: vec_norm

Overview:
- Parametrised successor to the two-input hypotenuse unit: computes the Euclidean norm floor(sqrt(sum x_i^2)) of a DIMS-element vector of unsigned WIDTH-bit values.
- Uses one shared shift-add squarer plus a bit-serial integer square root, both internal; no sub-module handshakes.
- Adds a mode that returns the raw sum of squares without the root, and a one-cycle done strobe.
- Sits in the datapath wherever the scalar unit sat, behind the same start/ready/busy handshake.

Parameters:
- WIDTH, 8, bit width of each vector element (>=2).
- DIMS, 3, number of vector elements (>=1).
- SUMW, 2*WIDTH+$clog2(DIMS), derived (localparam): width of the sum of squares.
- RW, (SUMW+1)/2, derived (localparam): width of the root.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- start  in  1  request; sampled only when ready=1
- mode  in  1  0 = norm (sqrt), 1 = sum of squares only
- x  in  DIMS*WIDTH  packed elements, element i at x[i*WIDTH +: WIDTH]
- ready  out  1  idle, will accept start
- busy  out  1  operation in progress
- done  out  1  one-cycle strobe, results just updated
- y  out  RW  floor(sqrt(sum)) (mode 0), 0 (mode 1)
- y_sq  out  SUMW  sum of squares (both modes)

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE, ready=1, busy=0, done=0, y=0, y_sq=0, internal registers cleared. Reset overrides everything, including mid-operation: the in-flight result is discarded and no done pulse is emitted.
- States: IDLE, SQUARE, ROOT, OUT.
- IDLE: at an edge with start=1, x and mode are latched and the accumulator is cleared -> SQUARE; ready=0, busy=1 from the next cycle. start=0 keeps the block in IDLE.
- While busy, start is ignored and x/mode changes have no effect.
- SQUARE: one shift-add step per cycle, element index 0..DIMS-1, WIDTH steps per element. Each element's square is added into a SUMW-bit accumulator on its last step. The accumulator cannot overflow by construction. Exactly DIMS*WIDTH cycles, then -> ROOT (mode 0) or -> OUT (mode 1).
- ROOT: binary digit-by-digit restoring root over the accumulator, one result bit per cycle, MSB first, exactly RW cycles. Result is the exact floor; no rounding. Then -> OUT.
- OUT: one cycle. Registers y_sq (and y, or 0 when mode=1), asserts done for that single cycle -> IDLE.
- Latency: edge E0 accepts start. Results, done=1, busy=0 and ready=1 all become visible after edge E0+L.
  - mode 0: L = DIMS*WIDTH + RW + 1.
  - mode 1: L = DIMS*WIDTH + 1.
  - Defaults: 34 and 25.
- ready = (state==IDLE), busy = !ready; both are registered-state decodes.
- Back-to-back: start held high while done=1 is accepted at that same edge (the IDLE cycle). The new operation begins with no bubble beyond that IDLE cycle.
- y and y_sq hold their values between operations until the next OUT or reset.
- DIMS=1: $clog2 term is 0; behaviour degenerates to y=x.

Test Plan:
- Defaults, mode 0, x={12,4,3}: start one cycle -> after 34 edges done=1 for one cycle, y_sq=169, y=13, ready=1.
- mode 0, x={255,255,255}: y_sq=195075, y=441 (floor, 442^2 exceeds); x={0,0,0} -> y_sq=0, y=0.
- mode 1, x={0,4,3}: done after 25 edges, y_sq=25, y=0. Then mode 0, x={0,1,1} back-to-back with start held -> y_sq=2, y=1 after 34 further edges.
- Pulse start again at edges 5 and 20 of an operation with different x -> ignored; result matches the first x; exactly one done pulse.
- Drive rst=0 at edge 10 of an operation -> next cycle ready=1, busy=0, y=0, y_sq=0, no done. A subsequent start with x={12,4,3} -> y=13.
- Parameter sweep WIDTH=4, DIMS=1 and WIDTH=12, DIMS=5: random vectors checked against a reference model (floor sqrt, exact sum, exact latency formula).

Source files
------------

// File: rtl/vec_norm.sv
// rtl/vec_norm.sv - Euclidean norm of a packed vector via shared shift-add squarer and serial root
module vec_norm #(
    parameter int WIDTH = 8,
    parameter int DIMS  = 3,
    localparam int SUMW = 2 * WIDTH + $clog2(DIMS),
    localparam int RW   = (SUMW + 1) / 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DIMS*WIDTH-1:0] x,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [RW-1:0]         y,
    output logic [SUMW-1:0]       y_sq
);

    localparam int PW  = 2 * WIDTH;
    localparam int OPW = 2 * RW;
    localparam int IW  = (DIMS > 1) ? $clog2(DIMS) : 1;
    localparam int BW  = $clog2(WIDTH);
    localparam int RCW = $clog2(RW);

    localparam logic [IW-1:0]  IDX_LAST  = IW'(DIMS - 1);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [RCW-1:0] RCNT_LAST = RCW'(RW - 1);

    typedef enum logic [1:0] {S_IDLE, S_SQUARE, S_ROOT, S_OUT} state_t;

    state_t state_q, state_d;

    logic [DIMS*WIDTH-1:0] xs_q, xs_d;
    logic                  mode_q, mode_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [PW-1:0]         prod_q, prod_d;
    logic [SUMW-1:0]       acc_q, acc_d;
    logic [OPW-1:0]        op_q, op_d;
    logic [RW:0]           rem_q, rem_d;
    logic [RW-1:0]         root_q, root_d;
    logic [RCW-1:0]        rcnt_q, rcnt_d;
    logic                  done_q, done_d;
    logic [RW-1:0]         y_q, y_d;
    logic [SUMW-1:0]       y_sq_q, y_sq_d;

    // The element being squared always sits in the low slice; xs_q shifts down per element.
    logic [WIDTH-1:0] cur;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    prod_sum;
    logic             sq_last_step;
    logic             sq_done;
    logic [RW+2:0]    rsh;
    logic [RW+2:0]    trial;
    logic             fits;

    assign cur          = xs_q[WIDTH-1:0];
    assign addend       = cur[bit_q] ? (PW'(cur) << bit_q) : '0;
    assign prod_sum     = prod_q + addend;
    assign sq_last_step = (bit_q == BIT_LAST);
    assign sq_done      = sq_last_step && (idx_q == IDX_LAST);

    // Restoring root step: bring down two operand bits, try subtracting 4*root+1.
    assign rsh   = {rem_q, op_q[OPW-1 -: 2]};
    assign trial = {1'b0, root_q, 2'b01};
    assign fits  = (rsh >= trial);

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_SQUARE;
            S_SQUARE: if (sq_done) state_d = mode_q ? S_OUT : S_ROOT;
            S_ROOT:   if (rcnt_q == RCNT_LAST) state_d = S_OUT;
            S_OUT:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs: handshake decoded from the registered state, results from holding registers
    always_comb begin
        ready = (state_q == S_IDLE);
        busy  = (state_q != S_IDLE);
        done  = done_q;
        y     = y_q;
        y_sq  = y_sq_q;
    end

    // Datapath next-state: latch operands, squarer steps, root steps, result capture
    always_comb begin
        xs_d   = xs_q;
        mode_d = mode_q;
        idx_d  = idx_q;
        bit_d  = bit_q;
        prod_d = prod_q;
        acc_d  = acc_q;
        op_d   = op_q;
        rem_d  = rem_q;
        root_d = root_q;
        rcnt_d = rcnt_q;
        done_d = 1'b0;
        y_d    = y_q;
        y_sq_d = y_sq_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    xs_d   = x;
                    mode_d = mode;
                    idx_d  = '0;
                    bit_d  = '0;
                    prod_d = '0;
                    acc_d  = '0;
                end
            end
            S_SQUARE: begin
                if (sq_last_step) begin
                    acc_d  = acc_q + SUMW'(prod_sum);
                    prod_d = '0;
                    bit_d  = '0;
                    idx_d  = idx_q + 1'b1;
                    xs_d   = xs_q >> WIDTH;
                end else begin
                    prod_d = prod_sum;
                    bit_d  = bit_q + 1'b1;
                end
                if (sq_done) begin
                    op_d   = OPW'(acc_d);
                    rem_d  = '0;
                    root_d = '0;
                    rcnt_d = '0;
                end
            end
            S_ROOT: begin
                op_d   = op_q << 2;
                rem_d  = fits ? (rsh[RW:0] - trial[RW:0]) : rsh[RW:0];
                root_d = {root_q[RW-2:0], fits};
                rcnt_d = rcnt_q + 1'b1;
            end
            S_OUT: begin
                y_sq_d = acc_q;
                y_d    = mode_q ? '0 : root_q;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers; reset drops any in-flight operation and clears results
    always_ff @(posedge clk) begin
        if (!rst) begin
            xs_q   <= '0;
            mode_q <= 1'b0;
            idx_q  <= '0;
            bit_q  <= '0;
            prod_q <= '0;
            acc_q  <= '0;
            op_q   <= '0;
            rem_q  <= '0;
            root_q <= '0;
            rcnt_q <= '0;
            done_q <= 1'b0;
            y_q    <= '0;
            y_sq_q <= '0;
        end else begin
            xs_q   <= xs_d;
            mode_q <= mode_d;
            idx_q  <= idx_d;
            bit_q  <= bit_d;
            prod_q <= prod_d;
            acc_q  <= acc_d;
            op_q   <= op_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            rcnt_q <= rcnt_d;
            done_q <= done_d;
            y_q    <= y_d;
            y_sq_q <= y_sq_d;
        end
    end

endmodule

// File: tb/tb_vec_norm.sv
// tb/tb_vec_norm.sv - self-checking bench for vec_norm
module tb_vec_norm;

    localparam int L0 = 34;
    localparam int L1 = 25;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [23:0] x = '0;
    logic        ready, busy, done;
    logic [8:0]  y;
    logic [17:0] y_sq;

    logic        start_a = 1'b0, mode_a = 1'b0;
    logic [3:0]  x_a = '0;
    logic        ready_a, busy_a, done_a;
    logic [3:0]  y_a;
    logic [7:0]  ysq_a;

    logic        start_b = 1'b0, mode_b = 1'b0;
    logic [59:0] x_b = '0;
    logic        ready_b, busy_b, done_b;
    logic [13:0] y_b;
    logic [26:0] ysq_b;

    vec_norm u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .x(x),
        .ready(ready), .busy(busy), .done(done), .y(y), .y_sq(y_sq)
    );

    vec_norm #(.WIDTH(4), .DIMS(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .x(x_a),
        .ready(ready_a), .busy(busy_a), .done(done_a), .y(y_a), .y_sq(ysq_a)
    );

    vec_norm #(.WIDTH(12), .DIMS(5)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .x(x_b),
        .ready(ready_b), .busy(busy_b), .done(done_b), .y(y_b), .y_sq(ysq_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int e0      = 0;
    int done_cnt = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint unsigned sumsq(input logic [63:0] v, input int w, input int d);
        longint unsigned s = 0;
        longint unsigned e;
        for (int i = 0; i < d; i++) begin
            e = (v >> (i * w)) & ((64'd1 << w) - 1);
            s += e * e;
        end
        return s;
    endfunction

    function automatic longint unsigned isqrt(input longint unsigned s);
        longint unsigned r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    // Transaction-level model of the default instance
    bit          m_pend = 1'b0;
    bit          m_done = 1'b0;
    int          m_edge = 0;
    logic [63:0] m_y = '0, m_sq = '0, p_y = '0, p_sq = '0;

    always @(posedge clk) begin
        bit was_idle;
        cyc++;
        if (!rst) begin
            m_pend = 1'b0;
            m_done = 1'b0;
            m_y    = '0;
            m_sq   = '0;
        end else begin
            was_idle = !m_pend;
            m_done   = 1'b0;
            if (m_pend && cyc == m_edge) begin
                m_pend = 1'b0;
                m_done = 1'b1;
                m_y    = p_y;
                m_sq   = p_sq;
            end
            if (was_idle && start) begin
                m_pend = 1'b1;
                m_edge = cyc + (mode ? L1 : L0);
                p_sq   = sumsq({40'd0, x}, 8, 3);
                p_y    = mode ? 64'd0 : isqrt(p_sq);
            end
        end
    end

    // Every cycle: handshake and results of the default instance against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", {63'd0, ready}, {63'd0, !m_pend});
            check("busy",  {63'd0, busy},  {63'd0, m_pend});
            check("done",  {63'd0, done},  {63'd0, m_done});
            check("y",     {55'd0, y},     m_y);
            check("y_sq",  {46'd0, y_sq},  m_sq);
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic launch(input logic [23:0] v, input logic m);
        x = v;
        mode = m;
        start = 1'b1;
        @(negedge clk);
        e0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int k = 0;
        while (done !== 1'b1 && k < 120) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
        lat = cyc - e0;
    endtask

    int          sw_sel = 0;
    logic        done_s;
    logic        ready_s;
    logic [63:0] y_s, ysq_s;

    assign done_s  = sw_sel ? done_b : done_a;
    assign ready_s = sw_sel ? ready_b : ready_a;
    assign y_s     = sw_sel ? {50'd0, y_b} : {60'd0, y_a};
    assign ysq_s   = sw_sel ? {37'd0, ysq_b} : {56'd0, ysq_a};

    task automatic sweep_one(input int sel, input logic [63:0] v, input logic m);
        int w, d, rw, l_exp, k;
        longint unsigned s, r;
        sw_sel = sel;
        w = sel ? 12 : 4;
        d = sel ? 5 : 1;
        rw = (2 * w + $clog2(d) + 1) / 2;
        s = sumsq(v, w, d);
        r = m ? 0 : isqrt(s);
        l_exp = d * w + (m ? 0 : rw) + 1;
        if (sel != 0) begin
            x_b = v[59:0]; mode_b = m; start_b = 1'b1;
        end else begin
            x_a = v[3:0]; mode_a = m; start_a = 1'b1;
        end
        @(negedge clk);
        e0 = cyc;
        start_a = 1'b0;
        start_b = 1'b0;
        k = 0;
        while (done_s !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("sw_done",    {63'd0, done_s}, 64'd1);
        check("sw_latency", 64'(cyc - e0), 64'(l_exp));
        check("sw_ready",   {63'd0, ready_s}, 64'd1);
        check("sw_y",       y_s, r);
        check("sw_y_sq",    ysq_s, s);
    endtask

    initial begin
        int lat;
        int snap;
        logic [63:0] v;

        rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        check("rst_ready", {63'd0, ready}, 64'd1);
        check("rst_y_sq",  {46'd0, y_sq}, 64'd0);

        check("model_sqrt_441", isqrt(195075), 64'd441);
        check("model_sumsq",    sumsq(64'h0C0403, 8, 3), 64'd169);

        launch({8'd12, 8'd4, 8'd3}, 1'b0);
        wait_done(lat);
        check("lat_mode0", 64'(lat), 64'd34);
        check("y_13",      {55'd0, y}, 64'd13);
        check("y_sq_169",  {46'd0, y_sq}, 64'd169);
        @(negedge clk);

        launch({8'd255, 8'd255, 8'd255}, 1'b0);
        wait_done(lat);
        check("y_441",       {55'd0, y}, 64'd441);
        check("y_sq_195075", {46'd0, y_sq}, 64'd195075);
        @(negedge clk);

        launch(24'd0, 1'b0);
        wait_done(lat);
        check("y_zero", {55'd0, y}, 64'd0);
        @(negedge clk);

        launch({8'd0, 8'd4, 8'd3}, 1'b1);
        wait_done(lat);
        check("lat_mode1", 64'(lat), 64'd25);
        check("y_sq_25",   {46'd0, y_sq}, 64'd25);
        check("y_mode1",   {55'd0, y}, 64'd0);

        launch({8'd0, 8'd1, 8'd1}, 1'b0);
        wait_done(lat);
        check("b2b_lat",  64'(lat), 64'd34);
        check("b2b_y_sq", {46'd0, y_sq}, 64'd2);
        check("b2b_y",    {55'd0, y}, 64'd1);
        @(negedge clk);

        snap = done_cnt;
        launch({8'd12, 8'd4, 8'd3}, 1'b0);
        repeat (3) @(negedge clk);
        x = {8'd200, 8'd7, 8'd9};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        x = {8'd1, 8'd1, 8'd1};
        mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = 1'b0;
        wait_done(lat);
        check("ign_lat", 64'(lat), 64'd34);
        check("ign_y",   {55'd0, y}, 64'd13);
        @(negedge clk);
        check("ign_one_done", 64'(done_cnt - snap), 64'd1);

        launch({8'd255, 8'd255, 8'd255}, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mid_rst_ready", {63'd0, ready}, 64'd1);
        check("mid_rst_busy",  {63'd0, busy}, 64'd0);
        check("mid_rst_done",  {63'd0, done}, 64'd0);
        check("mid_rst_y",     {55'd0, y}, 64'd0);
        check("mid_rst_y_sq",  {46'd0, y_sq}, 64'd0);
        snap = done_cnt;
        repeat (40) @(negedge clk);
        check("mid_rst_no_done", 64'(done_cnt - snap), 64'd0);
        launch({8'd12, 8'd4, 8'd3}, 1'b0);
        wait_done(lat);
        check("post_rst_y", {55'd0, y}, 64'd13);
        @(negedge clk);

        sweep_one(0, 64'hF, 1'b0);
        sweep_one(0, 64'h0, 1'b0);
        sweep_one(0, 64'hF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            v = {32'd0, $urandom};
            sweep_one(0, v, 1'($urandom_range(0, 1)));
        end
        sweep_one(1, 64'h0FFF_FFFF_FFFF_FFFF, 1'b0);
        sweep_one(1, 64'h0FFF_FFFF_FFFF_FFFF, 1'b1);
        for (int i = 0; i < 6; i++) begin
            v = {$urandom, $urandom};
            sweep_one(1, v, 1'($urandom_range(0, 1)));
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
